// File: rtl/alu_req_sched_pkg.sv
// Shared definitions for the ALU request scheduler: op codes, FSM states and
// the divide-by-zero helper used at grant time.
package alu_req_sched_pkg;

   typedef enum logic [1:0] {
      OP_ADD = 2'b00,
      OP_SUB = 2'b01,
      OP_MUL = 2'b10,
      OP_DIV = 2'b11
   } op_t;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_WAIT  = 2'd2,
      ST_RESP  = 2'd3
   } state_t;

   // A division with a zero divisor is answered locally and never reaches the ALU.
   function automatic logic is_div_by_zero(input logic [1:0] op, input logic zero_b);
      return (op == OP_DIV) && zero_b;
   endfunction

endpackage

// File: rtl/alu_req_sched_rr_arb2.sv
// Two-way round-robin arbiter: a lone requester always wins; on a tie the
// pointer decides, and after each grant the pointer moves to the other client.
module alu_req_sched_rr_arb2 (
   input  logic       clk,
   input  logic       rst,
   input  logic [1:0] req,
   input  logic       advance,
   output logic [1:0] gnt,
   output logic       ptr
);

   always_comb begin
      gnt = req;
      if (req == 2'b11) begin
         gnt = ptr ? 2'b10 : 2'b01;
      end
   end

   // gnt[0] set means client 0 just won, so client 1 gets priority next time.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ptr <= 1'b0;
      end else if (advance && (req != 2'b00)) begin
         ptr <= gnt[0];
      end
   end

endmodule

// File: rtl/alu_req_sched.sv
// Shares one multi-cycle ALU between two clients: round-robin grant, BGN pulse,
// wait for END (with timeout), then hold the result until the owner takes it.
module alu_req_sched
   import alu_req_sched_pkg::*;
#(
   parameter int DATA_W  = 8,
   parameter int TIMEOUT = 64,
   parameter int TO_W    = 7
) (
   input  logic                       clk,
   input  logic                       rst,
   // Handshake: a request transfers on a rising edge where req_valid[i] and
   // req_ready[i] are both 1; a response transfers on an edge where
   // rsp_valid[i] and rsp_ready[i] are both 1. valid never waits on ready.
   input  logic [1:0]                 req_valid,
   input  logic [1:0][1:0]            req_op,
   input  logic [1:0][DATA_W-1:0]     req_a,
   input  logic [1:0][DATA_W-1:0]     req_b,
   output logic [1:0]                 req_ready,
   output logic [1:0]                 rsp_valid,
   output logic [1:0][2*DATA_W-1:0]   rsp_data,
   output logic [1:0]                 rsp_err,
   input  logic [1:0]                 rsp_ready,
   output logic                       alu_bgn,
   output logic [1:0]                 alu_op,
   output logic [DATA_W-1:0]          alu_a,
   output logic [DATA_W-1:0]          alu_b,
   input  logic                       alu_end,
   input  logic [2*DATA_W-1:0]        alu_res,
   output logic [1:0]                 state_dbg,
   output logic                       rr_ptr
);

   state_t                state_q, state_d;
   logic [1:0]            gnt;
   logic                  grant;
   logic                  sel;
   logic [1:0]            sel_op;
   logic [DATA_W-1:0]     sel_a, sel_b;
   logic                  div0;
   logic                  owner_q;
   logic [1:0]            op_q;
   logic [DATA_W-1:0]     a_q, b_q;
   logic [2*DATA_W-1:0]   res_q;
   logic                  err_q;
   logic [TO_W-1:0]       to_cnt_q;
   logic                  to_hit;

   assign grant  = (state_q == ST_IDLE) && (req_valid != 2'b00);
   assign sel    = gnt[1];
   assign sel_op = req_op[sel];
   assign sel_a  = req_a[sel];
   assign sel_b  = req_b[sel];
   assign div0   = is_div_by_zero(sel_op, sel_b == '0);
   assign to_hit = (to_cnt_q == TO_W'(TIMEOUT - 1));

   alu_req_sched_rr_arb2 u_arb (
      .clk     (clk),
      .rst     (rst),
      .req     (req_valid),
      .advance (grant),
      .gnt     (gnt),
      .ptr     (rr_ptr)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_IDLE:  if (grant) state_d = div0 ? ST_RESP : ST_ISSUE;
         ST_ISSUE: state_d = ST_WAIT;
         ST_WAIT:  if (alu_end || to_hit) state_d = ST_RESP;
         ST_RESP:  if (rsp_ready[owner_q]) state_d = ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase
   end

   // Operand, owner, result and timeout registers; only the FSM state decides
   // which of them move in a given cycle.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         owner_q  <= 1'b0;
         op_q     <= '0;
         a_q      <= '0;
         b_q      <= '0;
         res_q    <= '0;
         err_q    <= 1'b0;
         to_cnt_q <= '0;
      end else begin
         unique case (state_q)
            ST_IDLE: begin
               if (grant) begin
                  owner_q <= sel;
                  op_q    <= sel_op;
                  a_q     <= sel_a;
                  b_q     <= sel_b;
                  if (div0) begin
                     res_q <= '0;
                     err_q <= 1'b1;
                  end
               end
            end
            ST_ISSUE: to_cnt_q <= '0;
            ST_WAIT: begin
               if (alu_end) begin
                  res_q <= alu_res;
                  err_q <= 1'b0;
               end else if (to_hit) begin
                  res_q <= '0;
                  err_q <= 1'b1;
               end else begin
                  to_cnt_q <= to_cnt_q + 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   // req_ready is masked by rst so nothing looks accepted while reset is held.
   always_comb begin
      req_ready = '0;
      rsp_valid = '0;
      rsp_data  = '0;
      rsp_err   = '0;
      alu_bgn   = 1'b0;
      unique case (state_q)
         ST_IDLE:  if (!rst) req_ready = gnt;
         ST_ISSUE: alu_bgn = 1'b1;
         ST_RESP: begin
            rsp_valid[owner_q] = 1'b1;
            rsp_data[owner_q]  = res_q;
            rsp_err[owner_q]   = err_q;
         end
         default: ;
      endcase
   end

   assign alu_op    = op_q;
   assign alu_a     = a_q;
   assign alu_b     = b_q;
   assign state_dbg = state_q;

endmodule

// File: tb/tb_alu_req_sched.sv
// Bench for alu_req_sched: a behavioural ALU with programmable END delay,
// a vector table, hand-written corner sequences and a randomized phase.
module tb_alu_req_sched;

  localparam int DATA_W  = 8;
  localparam int TIMEOUT = 64;

  typedef struct {
    logic [1:0]  op;
    logic [7:0]  a;
    logic [7:0]  b;
    int          dly;
    logic [15:0] exp_data;
    logic        exp_err;
  } vec_t;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [1:0]           req_valid;
  logic [1:0][1:0]      req_op;
  logic [1:0][7:0]      req_a;
  logic [1:0][7:0]      req_b;
  logic [1:0]           req_ready;
  logic [1:0]           rsp_valid;
  logic [1:0][15:0]     rsp_data;
  logic [1:0]           rsp_err;
  logic [1:0]           rsp_ready;
  logic                 alu_bgn;
  logic [1:0]           alu_op;
  logic [7:0]           alu_a;
  logic [7:0]           alu_b;
  logic                 alu_end;
  logic [15:0]          alu_res;
  logic [1:0]           state_dbg;
  logic                 rr_ptr;

  int cmp_count  = 0;
  int fail_count = 0;

  int alu_delay  = 1;
  bit alu_hang   = 1'b0;
  int bgn_count  = 0;
  int inject_req = 0;
  int prefer     = 0;

  logic [16:0] exp_q[$];
  vec_t        vecs[9];

  alu_req_sched #(.DATA_W(DATA_W), .TIMEOUT(TIMEOUT), .TO_W(7)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_op    (req_op),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rsp_data  (rsp_data),
    .rsp_err   (rsp_err),
    .rsp_ready (rsp_ready),
    .alu_bgn   (alu_bgn),
    .alu_op    (alu_op),
    .alu_a     (alu_a),
    .alu_b     (alu_b),
    .alu_end   (alu_end),
    .alu_res   (alu_res),
    .state_dbg (state_dbg),
    .rr_ptr    (rr_ptr)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- reference functions ----------------
  function automatic logic [15:0] alu_fn(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b);
    case (op)
      2'b00:   return 16'(a) + 16'(b);
      2'b01:   return 16'(a) - 16'(b);
      2'b10:   return 16'(a) * 16'(b);
      default: return (b == 8'd0) ? 16'd0 : {a % b, a / b};
    endcase
  endfunction

  function automatic logic [16:0] ref_rsp(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b);
    if (op == 2'b11 && b == 8'd0) return {1'b1, 16'd0};
    return {1'b0, alu_fn(op, a, b)};
  endfunction

  // ---------------- behavioural ALU ----------------
  initial begin : alu_model
    int cnt;
    int inj_done;
    logic [1:0] m_op;
    logic [7:0] m_a, m_b;
    cnt = 0; inj_done = 0; m_op = 2'b00; m_a = 8'd0; m_b = 8'd0;
    alu_end = 1'b0;
    alu_res = 16'd0;
    forever begin
      @(posedge clk); #1;
      alu_end = 1'b0;
      if (rst) begin
        cnt = 0;
      end else if (alu_bgn) begin
        bgn_count++;
        m_op = alu_op; m_a = alu_a; m_b = alu_b;
        cnt = alu_hang ? 0 : alu_delay;
      end else if (cnt > 0) begin
        cnt--;
        if (cnt == 0) begin
          alu_end = 1'b1;
          alu_res = alu_fn(m_op, m_a, m_b);
        end
      end
      if (inject_req != inj_done) begin
        inj_done = inject_req;
        alu_end  = 1'b1;
        alu_res  = 16'hBEEF;
      end
    end
  end

  // ---------------- checking helpers ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    cmp_count++;
    if (act !== exp) begin
      fail_count++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic flag_fail(input string name);
    cmp_count++;
    fail_count++;
    $display("FAIL %s: DUT event did not occur within the cycle budget", name);
  endtask

  // ---------------- driver tasks (all return at posedge+1) ----------------
  task automatic start_req(input int c, input logic [1:0] op, input logic [7:0] a, input logic [7:0] b);
    req_valid[c] = 1'b1;
    req_op[c]    = op;
    req_a[c]     = a;
    req_b[c]     = b;
  endtask

  task automatic wait_grant_any(output int who, output bit ok, output int waited);
    who = -1; ok = 1'b0; waited = 0;
    for (int n = 0; n < 300; n++) begin
      @(negedge clk);
      if (req_ready != 2'b00) begin
        ok = 1'b1;
        who = req_ready[1] ? 1 : 0;
        waited = n;
        check("grant_onehot", 32'(req_ready), (who == 1) ? 32'd2 : 32'd1);
        break;
      end
    end
    if (!ok) flag_fail("grant_wait");
    @(posedge clk); #1;
    if (ok) begin
      req_valid[who] = 1'b0;
      prefer = 1 - who;
    end
  endtask

  task automatic wait_rsp(input int c, output int lat, output bit other, output bit ok);
    lat = 0; other = 1'b0; ok = 1'b0;
    for (int n = 0; n < 300; n++) begin
      @(negedge clk);
      lat++;
      if (rsp_valid[1-c]) other = 1'b1;
      if (rsp_valid[c]) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) flag_fail("rsp_wait");
    @(posedge clk); #1;
  endtask

  task automatic finish_rsp(input int c, input int hold, output logic [15:0] data, output logic err);
    logic [15:0] d0;
    bit stable;
    d0 = rsp_data[c];
    stable = 1'b1;
    for (int n = 0; n < hold; n++) begin
      @(negedge clk);
      if (!rsp_valid[c] || rsp_data[c] !== d0) stable = 1'b0;
      @(posedge clk); #1;
    end
    rsp_ready[c] = 1'b1;
    @(negedge clk);
    data = rsp_data[c];
    err  = rsp_err[c];
    check("rsp_hold_stable", 32'(stable), 32'd1);
    @(posedge clk); #1;
    rsp_ready[c] = 1'b0;
    check("rsp_dropped", 32'(rsp_valid[c]), 32'd0);
  endtask

  task automatic run_txn(input int c, input logic [1:0] op, input logic [7:0] a, input logic [7:0] b,
                         input int dly, input bit hang, input int hold,
                         output logic [15:0] data, output logic err, output int lat,
                         output bit other, output int bgn_delta);
    int who, waited, b0;
    bit ok;
    data = 16'd0; err = 1'b0; lat = 0; other = 1'b0; bgn_delta = 0;
    alu_delay = dly; alu_hang = hang; b0 = bgn_count;
    start_req(c, op, a, b);
    wait_grant_any(who, ok, waited);
    req_valid[c] = 1'b0;
    if (!ok) return;
    check("txn_grant_client", 32'(who), 32'(c));
    wait_rsp(c, lat, other, ok);
    if (!ok) return;
    finish_rsp(c, hold, data, err);
    bgn_delta = bgn_count - b0;
  endtask

  // ---------------- main sequence ----------------
  initial begin : main
    logic [15:0] d, d0;
    logic        e;
    int          lat, bd, who, waited, dly, exp_who, mask;
    bit          oth, ok, bad_rdy, bad_data, abort;
    logic [16:0] exp;
    logic [1:0]  p_op[2];
    logic [7:0]  p_a[2], p_b[2];
    bit          pend[2];

    vecs[0] = '{2'b10, 8'd7,   8'd6,   12, 16'd42,   1'b0};
    vecs[1] = '{2'b00, 8'd7,   8'd6,   1,  16'd13,   1'b0};
    vecs[2] = '{2'b01, 8'd5,   8'd9,   3,  16'hFFFC, 1'b0};
    vecs[3] = '{2'b10, 8'd12,  8'd11,  2,  16'd132,  1'b0};
    vecs[4] = '{2'b11, 8'd100, 8'd7,   4,  16'h020E, 1'b0};
    vecs[5] = '{2'b11, 8'd9,   8'd0,   5,  16'd0,    1'b1};
    vecs[6] = '{2'b11, 8'd255, 8'd1,   1,  16'h00FF, 1'b0};
    vecs[7] = '{2'b00, 8'd255, 8'd255, 6,  16'h01FE, 1'b0};
    vecs[8] = '{2'b11, 8'd0,   8'd0,   2,  16'd0,    1'b1};

    // Reset, with both clients requesting so a leaking req_ready would show.
    rst = 1'b1; req_valid = 2'b11; req_op = '0; req_a = '0; req_b = '0; rsp_ready = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_state",     32'(state_dbg), 32'd0);
    check("rst_req_ready", 32'(req_ready), 32'd0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_rsp_data",  32'(rsp_data),  32'd0);
    check("rst_alu_bgn",   32'(alu_bgn),   32'd0);
    check("rst_alu_ops",   32'({alu_op, alu_a, alu_b}), 32'd0);
    check("rst_rr_ptr",    32'(rr_ptr),    32'd0);
    req_valid = 2'b00;
    rst = 1'b0;
    @(posedge clk); #1;

    // Arbitration: tie after reset -> 0 then 1; lone 0; tie again -> 1 then 0.
    alu_delay = 2; alu_hang = 1'b0;
    start_req(0, 2'b00, 8'd1, 8'd2);
    start_req(1, 2'b00, 8'd3, 8'd4);
    wait_grant_any(who, ok, waited);
    check("arb_tie1_first", 32'(who), 32'd0);
    wait_rsp(0, lat, oth, ok);
    finish_rsp(0, 0, d, e);
    check("arb_tie1_data0", 32'(d), 32'd3);
    wait_grant_any(who, ok, waited);
    check("arb_tie1_second", 32'(who), 32'd1);
    wait_rsp(1, lat, oth, ok);
    finish_rsp(1, 0, d, e);
    check("arb_tie1_data1", 32'(d), 32'd7);
    run_txn(0, 2'b01, 8'd10, 8'd3, 2, 1'b0, 0, d, e, lat, oth, bd);
    check("arb_lone_data", 32'(d), 32'd7);
    start_req(0, 2'b00, 8'd5, 8'd5);
    start_req(1, 2'b00, 8'd6, 8'd6);
    wait_grant_any(who, ok, waited);
    check("arb_tie2_first", 32'(who), 32'd1);
    wait_rsp(1, lat, oth, ok);
    finish_rsp(1, 1, d, e);
    check("arb_tie2_data1", 32'(d), 32'd12);
    wait_grant_any(who, ok, waited);
    check("arb_tie2_second", 32'(who), 32'd0);
    wait_rsp(0, lat, oth, ok);
    finish_rsp(0, 0, d, e);
    check("arb_tie2_data0", 32'(d), 32'd10);

    // Vector table on client 0.
    for (int i = 0; i < 9; i++) begin
      run_txn(0, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].dly, 1'b0, i % 3, d, e, lat, oth, bd);
      check($sformatf("vec%0d_data", i),  32'(d),   32'(vecs[i].exp_data));
      check($sformatf("vec%0d_err", i),   32'(e),   32'(vecs[i].exp_err));
      check($sformatf("vec%0d_lat", i),   32'(lat), vecs[i].exp_err ? 32'd1 : 32'(2 + vecs[i].dly));
      check($sformatf("vec%0d_bgn", i),   32'(bd),  vecs[i].exp_err ? 32'd0 : 32'd1);
      check($sformatf("vec%0d_other", i), 32'(oth), 32'd0);
    end

    // END never arrives -> timeout answer, then normal service resumes.
    run_txn(1, 2'b00, 8'd1, 8'd1, 1, 1'b1, 0, d, e, lat, oth, bd);
    check("to_err",  32'(e),   32'd1);
    check("to_data", 32'(d),   32'd0);
    check("to_lat",  32'(lat), 32'(2 + TIMEOUT));
    check("to_bgn",  32'(bd),  32'd1);
    check("to_idle", 32'(state_dbg), 32'd0);
    run_txn(1, 2'b00, 8'd20, 8'd22, 2, 1'b0, 0, d, e, lat, oth, bd);
    check("to_next_data", 32'(d), 32'd42);
    check("to_next_err",  32'(e), 32'd0);

    // Response held off for 20 cycles while client 1 waits.
    alu_delay = 3; alu_hang = 1'b0;
    start_req(0, 2'b10, 8'd9, 8'd9);
    wait_grant_any(who, ok, waited);
    wait_rsp(0, lat, oth, ok);
    start_req(1, 2'b01, 8'd50, 8'd8);
    d0 = rsp_data[0];
    bad_rdy = 1'b0; bad_data = 1'b0;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (req_ready != 2'b00) bad_rdy = 1'b1;
      if (rsp_data[0] !== 16'd81 || !rsp_valid[0]) bad_data = 1'b1;
      @(posedge clk); #1;
    end
    check("hold_req_ready_low", 32'(bad_rdy),  32'd0);
    check("hold_data_stable",   32'(bad_data), 32'd0);
    check("hold_data_value",    32'(d0),       32'd81);
    finish_rsp(0, 0, d, e);
    wait_grant_any(who, ok, waited);
    check("hold_next_client", 32'(who),    32'd1);
    check("hold_next_wait",   32'(waited), 32'd0);
    wait_rsp(1, lat, oth, ok);
    finish_rsp(1, 0, d, e);
    check("hold_next_data", 32'(d), 32'd42);

    // Reset in WAIT, then a stray END, then a fresh request.
    alu_delay = 30;
    start_req(0, 2'b10, 8'd3, 8'd5);
    wait_grant_any(who, ok, waited);
    repeat (5) begin @(posedge clk); #1; end
    @(negedge clk);
    check("rst6_pre_state", 32'(state_dbg), 32'd2);
    rst = 1'b1;
    #1;
    check("rst6_state",   32'(state_dbg), 32'd0);
    check("rst6_outputs", 32'({alu_bgn, alu_op, alu_a, alu_b, rsp_valid, req_ready}), 32'd0);
    check("rst6_rsp",     32'({rsp_data, rsp_err}), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    prefer = 0;
    @(posedge clk); #1;
    inject_req++;
    bad_rdy = 1'b0;
    for (int n = 0; n < 4; n++) begin
      @(negedge clk);
      if (rsp_valid != 2'b00 || state_dbg != 2'd0) bad_rdy = 1'b1;
      @(posedge clk); #1;
    end
    check("rst6_late_end_ignored", 32'(bad_rdy), 32'd0);
    run_txn(0, 2'b10, 8'd3, 8'd5, 3, 1'b0, 0, d, e, lat, oth, bd);
    check("rst6_fresh_data", 32'(d), 32'd15);
    check("rst6_fresh_err",  32'(e), 32'd0);

    // Randomized traffic against the scoreboard.
    abort = 1'b0;
    for (int it = 0; it < 40 && !abort; it++) begin
      mask = $urandom_range(1, 3);
      for (int c = 0; c < 2; c++) begin
        pend[c] = (((mask >> c) & 1) != 0);
        if (pend[c]) begin
          p_op[c] = 2'($urandom_range(0, 3));
          p_a[c]  = 8'($urandom);
          p_b[c]  = ($urandom_range(0, 5) == 0) ? 8'd0 : 8'($urandom);
          start_req(c, p_op[c], p_a[c], p_b[c]);
        end
      end
      while ((pend[0] || pend[1]) && !abort) begin
        exp_who = (pend[0] && pend[1]) ? prefer : (pend[0] ? 0 : 1);
        dly = $urandom_range(1, 6);
        alu_delay = dly; alu_hang = 1'b0;
        wait_grant_any(who, ok, waited);
        if (!ok) begin
          abort = 1'b1;
          req_valid = 2'b00;
          break;
        end
        check("rnd_arb", 32'(who), 32'(exp_who));
        pend[who] = 1'b0;
        exp_q.push_back(ref_rsp(p_op[who], p_a[who], p_b[who]));
        wait_rsp(who, lat, oth, ok);
        if (!ok) begin
          abort = 1'b1;
          req_valid = 2'b00;
          break;
        end
        check("rnd_other", 32'(oth), 32'd0);
        check("rnd_lat", 32'(lat),
              (p_op[who] == 2'b11 && p_b[who] == 8'd0) ? 32'd1 : 32'(2 + dly));
        finish_rsp(who, $urandom_range(0, 3), d, e);
        exp = exp_q.pop_front();
        check("rnd_data", 32'(d), 32'(exp[15:0]));
        check("rnd_err",  32'(e), 32'(exp[16]));
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_count, fail_count);
    $finish;
  end

endmodule
